bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of bus masters, range 2..8.
REQ-002 Parameter GRANT_TIMEOUT, default 16: max cycles a granted master may take to assert begin_transaction, range 2..255.
REQ-003 clock  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 request  input  NUM_REQ  per-master bus request, level-held, bit i = master i.
REQ-006 begin_transactionIN  input  1  observed bus begin_transaction strobe.
REQ-007 end_transactionIN  input  1  observed bus end_transaction strobe.
REQ-008 errorIN  input  1  observed bus error strobe.
REQ-009 granted  output  NUM_REQ  one-hot-or-zero grant, registered.
REQ-010 bus_idle  output  1  high when no master holds a grant.
REQ-011 timeout_pulse  output  1  one-cycle pulse when a grant is revoked for timeout.

Function
REQ-012 FSM states: IDLE, GRANTED, ACTIVE, TURNAROUND.
REQ-013 IDLE: if any request bit is set, select a winner round-robin, set granted to its one-hot code next cycle and go to GRANTED; otherwise stay.
REQ-014 Round-robin: search starts at index (last_winner+1) mod NUM_REQ and wraps; after reset last_winner = NUM_REQ-1, so master 0 has first priority.
REQ-015 GRANTED: begin_transactionIN -> ACTIVE; the winner's request drops before begin -> TURNAROUND; wait counter reaches GRANT_TIMEOUT -> TURNAROUND with timeout_pulse for one cycle.
REQ-016 The wait counter is 8 bits, cleared on entry to GRANTED, increments each GRANTED cycle and saturates.
REQ-017 ACTIVE: hold the grant regardless of the request level until end_transactionIN or errorIN, then go to TURNAROUND.
REQ-018 If begin_transactionIN and end_transactionIN are high in the same GRANTED cycle, go directly to TURNAROUND.
REQ-019 TURNAROUND: granted = 0 for exactly one cycle, then IDLE. Minimum gap between successive grants is 2 cycles (TURNAROUND + IDLE).
REQ-020 last_winner updates only when a grant is issued, so a timed-out master loses priority like a normal one.
REQ-021 Request changes by non-winning masters never affect the current grant.
REQ-022 granted has at most one bit set in every cycle.
REQ-023 bus_idle = 1 exactly when state is IDLE or TURNAROUND.
REQ-024 Request-to-grant latency from IDLE is 1 cycle.

Reset
REQ-025 While reset = 0 at a rising clock edge: state = IDLE, granted = 0, timeout_pulse = 0, wait counter = 0, last_winner = NUM_REQ-1.
REQ-026 bus_idle = 1 during and immediately after reset.
REQ-027 Reset asserted in any state, including mid-transaction, drops the grant at that edge without a TURNAROUND cycle.

Structure
REQ-028 A shared package holds the state encoding (2-bit, IDLE = 0), the default parameter constants and the counter width (8).
REQ-029 The round-robin search is a separate combinational sub-module, rr_priority_select (inputs: request vector and pointer; outputs: one-hot winner and valid flag); the FSM and counters stay in bus_arbiter.
REQ-030 All outputs are driven from flops, with no combinational path from inputs to granted.

Verification
REQ-031 After reset, request = 4'b0101 -> granted = 4'b0001 one cycle later; begin, then end 3 cycles later -> granted = 0 for 1 cycle, then granted = 4'b0100.
REQ-032 request = 4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3 with a 2-cycle gap between grants.
REQ-033 Master 2 granted, begin never asserted -> after 16 GRANTED cycles timeout_pulse = 1 for one cycle, then granted = 0; the next grant goes to master 3 if it is requesting.
REQ-034 errorIN pulses in ACTIVE while the request is still high -> TURNAROUND on the next cycle; the same master is re-granted only after the other requesters have been served.
REQ-035 Reset driven low in ACTIVE -> granted = 0 and bus_idle = 1 at that edge; after release with request = 4'b1000, master 3 is granted after master 0's turn is skipped, since last_winner = 3 gives master 0 priority only if it is requesting.
REQ-036 Begin and end asserted in the same cycle with a 1-word transfer -> no ACTIVE state; granted clears the next cycle; the one-hot invariant holds throughout every test.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// default parameters, counter width and small helpers.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_GRANTED    = 2'd1,
      ST_ACTIVE     = 2'd2,
      ST_TURNAROUND = 2'd3
   } arb_state_e;

   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_GRANT_TIMEOUT = 16;
   localparam int WAIT_CNT_W        = 8;
   localparam int MAX_REQ           = 8;

   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational round-robin search: first requesting index at or after
// the pointer, wrapping around the request vector.
module rr_priority_select
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [IDX_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   always_comb begin
      int             idx;
      logic [IDX_W-1:0] idx_sel;
      winner  = '0;
      valid   = 1'b0;
      idx     = 0;
      idx_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(pointer) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_sel = IDX_W'(idx);
         if (!valid && request[idx_sel]) begin
            winner[idx_sel] = 1'b1;
            valid           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one master at a time, tracks the bus
// transaction strobes and revokes grants that are never used.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] request,
   input  logic               begin_transactionIN,
   input  logic               end_transactionIN,
   input  logic               errorIN,
   output logic [NUM_REQ-1:0] granted,
   output logic               bus_idle,
   output logic               timeout_pulse
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e            state_q, state_d;
   logic [NUM_REQ-1:0]    granted_q, granted_d;
   logic                  timeout_pulse_q, timeout_pulse_d;
   logic                  bus_idle_q, bus_idle_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]      last_winner_q, last_winner_d;

   logic [IDX_W-1:0]      rr_ptr;
   logic [NUM_REQ-1:0]    rr_winner;
   logic                  rr_valid;
   logic [WAIT_CNT_W-1:0] wait_cnt_inc;
   logic                  owner_req;

   assign rr_ptr       = (last_winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_winner_q + 1'b1;
   assign owner_req    = |(request & granted_q);
   assign wait_cnt_inc = sat_inc(wait_cnt_q);

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .request (request),
      .pointer (rr_ptr),
      .winner  (rr_winner),
      .valid   (rr_valid)
   );

   always_comb begin
      state_d         = state_q;
      granted_d       = granted_q;
      timeout_pulse_d = 1'b0;
      wait_cnt_d      = wait_cnt_q;
      last_winner_d   = last_winner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rr_valid) begin
               state_d       = ST_GRANTED;
               granted_d     = rr_winner;
               wait_cnt_d    = '0;
               last_winner_d = IDX_W'(onehot_to_idx(MAX_REQ'(rr_winner)));
            end
         end
         ST_GRANTED: begin
            wait_cnt_d = wait_cnt_inc;
            // A single-word transfer shows begin and end together and skips ACTIVE.
            if (begin_transactionIN && end_transactionIN) begin
               state_d   = ST_TURNAROUND;
               granted_d = '0;
            end else if (begin_transactionIN) begin
               state_d = ST_ACTIVE;
            end else if (!owner_req) begin
               state_d   = ST_TURNAROUND;
               granted_d = '0;
            end else if (wait_cnt_inc >= WAIT_CNT_W'(GRANT_TIMEOUT)) begin
               state_d         = ST_TURNAROUND;
               granted_d       = '0;
               timeout_pulse_d = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (end_transactionIN || errorIN) begin
               state_d   = ST_TURNAROUND;
               granted_d = '0;
            end
         end
         ST_TURNAROUND: begin
            state_d   = ST_IDLE;
            granted_d = '0;
         end
         default: begin
            state_d   = ST_IDLE;
            granted_d = '0;
         end
      endcase
      bus_idle_d = (state_d == ST_IDLE) || (state_d == ST_TURNAROUND);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         granted_q       <= '0;
         timeout_pulse_q <= 1'b0;
         bus_idle_q      <= 1'b1;
         wait_cnt_q      <= '0;
         last_winner_q   <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q         <= state_d;
         granted_q       <= granted_d;
         timeout_pulse_q <= timeout_pulse_d;
         bus_idle_q      <= bus_idle_d;
         wait_cnt_q      <= wait_cnt_d;
         last_winner_q   <= last_winner_d;
      end
   end

   assign granted       = granted_q;
   assign bus_idle      = bus_idle_q;
   assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic         clock;
   logic         reset;
   logic [N-1:0] request;
   logic         begin_t;
   logic         end_t;
   logic         error_t;
   logic [N-1:0] granted;
   logic         bus_idle;
   logic         timeout_pulse;

   int n_checks = 0;
   int n_errors = 0;

   bus_arbiter #(
      .NUM_REQ       (N),
      .GRANT_TIMEOUT (TO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .request             (request),
      .begin_transactionIN (begin_t),
      .end_transactionIN   (end_t),
      .errorIN             (error_t),
      .granted             (granted),
      .bus_idle            (bus_idle),
      .timeout_pulse       (timeout_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the bus, whether the transfer started,
   // how long the owner has waited, and how many edges of blanking remain.
   int       m_owner   = -1;
   bit       m_started = 1'b0;
   int       m_wait    = 0;
   int       m_blank   = 0;
   int       m_last    = N - 1;
   bit       m_pulse   = 1'b0;

   task model_release();
      m_owner = -1;
      m_blank = 1;
   endtask

   task model_step();
      m_pulse = 1'b0;
      if (reset !== 1'b1) begin
         m_owner   = -1;
         m_started = 1'b0;
         m_wait    = 0;
         m_blank   = 0;
         m_last    = N - 1;
      end else if (m_owner < 0) begin
         if (m_blank > 0) begin
            m_blank--;
         end else begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (m_owner < 0 && request[c]) begin
                  m_owner   = c;
                  m_last    = c;
                  m_wait    = 0;
                  m_started = 1'b0;
               end
            end
         end
      end else if (!m_started) begin
         m_wait++;
         if (begin_t && end_t)            model_release();
         else if (begin_t)                m_started = 1'b1;
         else if (!request[m_owner])      model_release();
         else if (m_wait >= TO) begin
            model_release();
            m_pulse = 1'b1;
         end
      end else begin
         if (end_t || error_t) model_release();
      end
   endtask

   always begin
      logic [N-1:0] exp_g;
      @(posedge clock);
      model_step();
      #1;
      exp_g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("model_granted", 32'(granted), 32'(exp_g));
      chk("model_bus_idle", 32'(bus_idle), 32'(m_owner < 0));
      chk("model_timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
      chk("onehot0", 32'($onehot0(granted)), 32'd1);
   end

   initial begin
      int idx;
      int zeros;
      reset   = 1'b0;
      request = '0;
      begin_t = 1'b0;
      end_t   = 1'b0;
      error_t = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_granted", 32'(granted), 32'h0);
      chk("rst_bus_idle", 32'(bus_idle), 32'h1);
      chk("rst_pulse", 32'(timeout_pulse), 32'h0);

      // Basic grant, transfer, turnaround, next requester
      reset = 1'b1; request = 4'b0101;
      @(negedge clock); chk("first_grant", 32'(granted), 32'h1); chk("busy", 32'(bus_idle), 32'h0);
      begin_t = 1'b1;
      @(negedge clock); begin_t = 1'b0; chk("active_hold", 32'(granted), 32'h1);
      @(negedge clock);
      @(negedge clock); end_t = 1'b1;
      @(negedge clock); end_t = 1'b0; chk("turnaround_g", 32'(granted), 32'h0); chk("turnaround_idle", 32'(bus_idle), 32'h1);
      @(negedge clock); chk("idle_gap_g", 32'(granted), 32'h0);
      @(negedge clock); chk("second_grant", 32'(granted), 32'h4); request = '0;
      @(negedge clock); chk("drop_release", 32'(granted), 32'h0);
      repeat (2) @(negedge clock);

      // Timeout of master 2, then master 3 served
      request = 4'b0100;
      @(negedge clock); chk("to_grant", 32'(granted), 32'h4); request = 4'b1100;
      repeat (15) @(negedge clock);
      chk("to_last_cycle_g", 32'(granted), 32'h4); chk("to_no_early_pulse", 32'(timeout_pulse), 32'h0);
      @(negedge clock); chk("to_pulse", 32'(timeout_pulse), 32'h1); chk("to_revoked", 32'(granted), 32'h0);
      @(negedge clock); chk("to_pulse_one_cycle", 32'(timeout_pulse), 32'h0);
      @(negedge clock); chk("to_next_master3", 32'(granted), 32'h8); begin_t = 1'b1;

      // Error in ACTIVE, others served before master 3 again
      @(negedge clock); begin_t = 1'b0; error_t = 1'b1;
      @(negedge clock); error_t = 1'b0; chk("err_turnaround", 32'(granted), 32'h0);
      @(negedge clock); chk("err_idle", 32'(granted), 32'h0);
      @(negedge clock); chk("err_other_first", 32'(granted), 32'h4); request = 4'b1000;
      repeat (2) @(negedge clock);
      @(negedge clock); chk("err_regrant3", 32'(granted), 32'h8); begin_t = 1'b1;

      // Reset in ACTIVE
      @(negedge clock); begin_t = 1'b0; reset = 1'b0;
      @(negedge clock); chk("rst_mid_g", 32'(granted), 32'h0); chk("rst_mid_idle", 32'(bus_idle), 32'h1);
      reset = 1'b1; request = 4'b1000;
      @(negedge clock); chk("rst_then_m3", 32'(granted), 32'h8); request = 4'b0010;

      // Begin and end together
      repeat (2) @(negedge clock);
      @(negedge clock); chk("be_grant", 32'(granted), 32'h2); begin_t = 1'b1; end_t = 1'b1;
      @(negedge clock); begin_t = 1'b0; end_t = 1'b0;
      chk("be_cleared", 32'(granted), 32'h0); chk("be_idle", 32'(bus_idle), 32'h1); request = '0;
      repeat (2) @(negedge clock);

      // Round-robin order with all masters requesting
      reset = 1'b0;
      @(negedge clock); reset = 1'b1; request = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         idx = -1; zeros = 0;
         for (int w = 0; w < 20 && idx < 0; w++) begin
            @(negedge clock);
            end_t = 1'b0;
            if (granted != '0) idx = $clog2(granted);
            else zeros++;
         end
         chk("rr_order", 32'(idx), 32'(t % 4));
         if (t > 0) chk("rr_gap", 32'(zeros), 32'd2);
         begin_t = 1'b1;
         @(negedge clock); begin_t = 1'b0; end_t = 1'b1;
      end
      @(negedge clock); end_t = 1'b0;

      // Randomized traffic in segments with different activity levels
      for (int seg = 0; seg < 4; seg++) begin
         int fp, bp, ep, rp_err, rp_rst;
         case (seg)
            0: begin fp = 4;  bp = 4;  ep = 4; rp_err = 16; rp_rst = 200; end
            1: begin fp = 64; bp = 40; ep = 4; rp_err = 32; rp_rst = 400; end
            2: begin fp = 2;  bp = 2;  ep = 2; rp_err = 8;  rp_rst = 200; end
            default: begin fp = 8; bp = 3; ep = 3; rp_err = 3; rp_rst = 50; end
         endcase
         for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            for (int b = 0; b < N; b++)
               if ($urandom_range(fp - 1) == 0) request[b] = ~request[b];
            begin_t = ($urandom_range(bp - 1) == 0);
            end_t   = ($urandom_range(ep - 1) == 0);
            error_t = ($urandom_range(rp_err - 1) == 0);
            reset   = ($urandom_range(rp_rst - 1) != 0);
         end
      end
      reset = 1'b1; begin_t = 1'b0; end_t = 1'b0; error_t = 1'b0;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
